// File: rtl/dds_pkg.sv
// ============================================================================
// dds_pkg : shared constants, FSM state type and helpers for dds_phase_gen
// Rev 1.0
// ============================================================================
`default_nettype none

package dds_pkg;

    localparam int FREQ_W     = 11;
    localparam int FREQ_MAX   = 1800;
    localparam int MUL_CYCLES = 11;
    localparam int CNT_W      = 4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as a bit mask over lfsr[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        LOAD = 2'd2
    } state_t;

    function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] code);
        return (code > FREQ_W'(FREQ_MAX)) ? FREQ_W'(FREQ_MAX) : code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dds_phase_gen_if.sv
// ============================================================================
// dds_phase_gen_if : frequency-control and phase-output bundle of dds_phase_gen
// Rev 1.0
// ============================================================================
`default_nettype none

interface dds_phase_gen_if
    import dds_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int ROM_AW  = 10
);
    logic [FREQ_W-1:0]  Address;
    logic               FreqChng;
    logic               PhaseRst;
    logic [ROM_AW-1:0]  PhaseAddr;
    logic [PHASE_W-1:0] TuneWord;
    logic               Busy;
    logic               Update;

    modport master (
        output Address, FreqChng, PhaseRst,
        input  PhaseAddr, TuneWord, Busy, Update
    );

    modport slave (
        input  Address, FreqChng, PhaseRst,
        output PhaseAddr, TuneWord, Busy, Update
    );

endinterface

`default_nettype wire

// File: rtl/dds_shift_mul.sv
// ============================================================================
// dds_shift_mul : 11-cycle shift-add multiply of a frequency code by K_STEP
// Rev 1.0
// ============================================================================
`default_nettype none

module dds_shift_mul
    import dds_pkg::*;
#(
    parameter int          PHASE_W = 24,
    parameter logic [12:0] K_STEP  = 13'd1000
)(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [FREQ_W-1:0]  operand,
    output logic                    done,
    output logic [PHASE_W-1:0]      product
);

    logic [FREQ_W-1:0]  r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic [PHASE_W-1:0] r_prod;
    logic [PHASE_W-1:0] w_addend;

    assign w_addend = PHASE_W'(K_STEP) << r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_prod <= '0;
        end else if (start) begin
            r_sr   <= operand;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_prod <= '0;
        end else if (r_run) begin
            if (r_sr[0]) begin
                r_prod <= r_prod + w_addend;
            end
            r_sr  <= r_sr >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(MUL_CYCLES - 1)) begin
                r_run <= 1'b0;
            end
        end
    end

    // Asserted during the cycle whose edge performs the final partial-product add.
    assign done    = r_run && (r_cnt == CNT_W'(MUL_CYCLES - 1));
    assign product = r_prod;

endmodule

`default_nettype wire

// File: rtl/dds_phase_gen.sv
// ============================================================================
// dds_phase_gen : DDS phase accumulator with multiplied tuning-word updates
// Optional PhaseAddr LFSR dither: define DDS_PHASE_DITHER_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int          PHASE_W = 24,
    parameter int          ROM_AW  = 10,
    parameter logic [12:0] K_STEP  = 13'd1000
)(
    input  wire logic       Fg_CLK,
    input  wire logic       RESET,
    dds_phase_gen_if.slave  bus
);

    state_t             r_state;
    state_t             w_next;
    logic               r_pending;
    logic [FREQ_W-1:0]  r_pend_addr;
    logic [PHASE_W-1:0] r_tune;
    logic [PHASE_W-1:0] r_acc;
    logic               w_start;
    logic [FREQ_W-1:0]  w_operand;
    logic               w_mul_done;
    logic [PHASE_W-1:0] w_product;

    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_operand = clamp_freq(bus.Address);
        case (r_state)
            IDLE: begin
                if (bus.FreqChng) begin
                    w_start = 1'b1;
                    w_next  = MUL;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = IDLE;
                // A strobe in the LOAD cycle itself supersedes anything pending.
                if (bus.FreqChng) begin
                    w_start = 1'b1;
                    w_next  = MUL;
                end else if (r_pending) begin
                    w_start   = 1'b1;
                    w_operand = clamp_freq(r_pend_addr);
                    w_next    = MUL;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            r_pending   <= 1'b0;
            r_pend_addr <= '0;
            r_tune      <= '0;
            r_acc       <= '0;
        end else begin
            if (r_state == LOAD) begin
                r_tune    <= w_product;
                r_pending <= 1'b0;
            end else if ((r_state == MUL) && bus.FreqChng) begin
                r_pending   <= 1'b1;
                r_pend_addr <= bus.Address;
            end
            r_acc <= bus.PhaseRst ? '0 : r_acc + r_tune;
        end
    end

    dds_shift_mul #(
        .PHASE_W (PHASE_W),
        .K_STEP  (K_STEP)
    ) u_mul (
        .clk     (Fg_CLK),
        .rst     (RESET),
        .start   (w_start),
        .operand (w_operand),
        .done    (w_mul_done),
        .product (w_product)
    );

`ifdef DDS_PHASE_DITHER_EN
    localparam int DITHER_W = ((PHASE_W - ROM_AW) > 16) ? 16 : (PHASE_W - ROM_AW);

    logic [15:0]        r_lfsr;
    logic [PHASE_W-1:0] w_dithered;

    always_ff @(posedge Fg_CLK or posedge RESET) begin
        if (RESET) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    // Dither perturbs only the ROM address; the accumulator stays exact.
    assign w_dithered    = r_acc + PHASE_W'(r_lfsr[DITHER_W-1:0]);
    assign bus.PhaseAddr = w_dithered[PHASE_W-1 -: ROM_AW];
`else
    assign bus.PhaseAddr = r_acc[PHASE_W-1 -: ROM_AW];
`endif

    assign bus.TuneWord = r_tune;
    assign bus.Busy     = (r_state != IDLE);
    assign bus.Update   = (r_state == LOAD);

endmodule

`default_nettype wire

// File: tb/tb_dds_phase_gen.sv
// ============================================================================
// tb_dds_phase_gen : scoreboard bench for dds_phase_gen
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dds_phase_gen;

    localparam int PHASE_W = 24;
    localparam int ROM_AW  = 10;

    typedef struct {
        int          strobe;
        int          load;
        logic [23:0] val;
    } op_t;

    logic Fg_CLK;
    logic RESET;

    dds_phase_gen_if #(.PHASE_W(PHASE_W), .ROM_AW(ROM_AW)) bus ();

    dds_phase_gen #(
        .PHASE_W (PHASE_W),
        .ROM_AW  (ROM_AW),
        .K_STEP  (13'd1000)
    ) dut (
        .Fg_CLK (Fg_CLK),
        .RESET  (RESET),
        .bus    (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cycle = 0;
    bit          mon_en = 1'b0;
    op_t         q[$];
    logic [23:0] m_acc  = '0;
    logic [23:0] m_tune = '0;
    logic [15:0] m_lfsr = 16'hACE1;

    initial begin
        Fg_CLK = 1'b0;
        forever #5 Fg_CLK = ~Fg_CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [9:0] exp_paddr();
        logic [23:0] s;
        s = m_acc;
`ifdef DDS_PHASE_DITHER_EN
        s = m_acc + {10'd0, m_lfsr[13:0]};
`endif
        return s[23:14];
    endfunction

    always @(posedge Fg_CLK) begin
        cycle++;
        if (RESET) begin
            m_acc  = '0;
            m_tune = '0;
            m_lfsr = 16'hACE1;
            q.delete();
        end else begin
            m_acc  = bus.PhaseRst ? 24'd0 : m_acc + m_tune;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            if (q.size() > 0 && q[0].load == cycle) begin
                m_tune = q[0].val;
                void'(q.pop_front());
            end
        end
    end

    always @(negedge Fg_CLK) begin
        if (mon_en) begin
            check_eq("tune",  32'(bus.TuneWord),  32'(m_tune));
            check_eq("paddr", 32'(bus.PhaseAddr), 32'(exp_paddr()));
            check_eq("busy",  32'(bus.Busy),
                     32'(q.size() > 0 && q[0].strobe <= cycle));
            check_eq("update", 32'(bus.Update),
                     32'(q.size() > 0 && q[0].load == cycle + 1));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Fg_CLK);
        #1;
    endtask

    // Called 1 time unit after an edge; the strobe is sampled at the next edge.
    task automatic strobe(input logic [10:0] addr);
        int          t;
        int          ld;
        logic [23:0] v;
        t = cycle + 1;
        v = 24'((addr > 11'd1800 ? 32'd1800 : 32'(addr)) * 1000);
        if (q.size() > 0 && t <= q[0].load) begin
            ld = q[0].load + 12;
            if (q.size() >= 2) q[1].val = v;
            else q.push_back('{strobe: t, load: ld, val: v});
        end else begin
            ld = t + 12;
            q.push_back('{strobe: t, load: ld, val: v});
        end
        bus.Address  = addr;
        bus.FreqChng = 1'b1;
        @(posedge Fg_CLK);
        #1;
        bus.FreqChng = 1'b0;
    endtask

    task automatic phase_rst_pulse();
        bus.PhaseRst = 1'b1;
        @(posedge Fg_CLK);
        #1;
        bus.PhaseRst = 1'b0;
    endtask

    task automatic reset_mid_cycle();
        #2;
        RESET  = 1'b1;
        m_acc  = '0;
        m_tune = '0;
        m_lfsr = 16'hACE1;
        q.delete();
        #1;
        check_eq("rst_tune",   32'(bus.TuneWord),  32'd0);
        check_eq("rst_paddr",  32'(bus.PhaseAddr), 32'd0);
        check_eq("rst_busy",   32'(bus.Busy),      32'd0);
        check_eq("rst_update", 32'(bus.Update),    32'd0);
        repeat (2) @(posedge Fg_CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        RESET        = 1'b0;
        bus.Address  = '0;
        bus.FreqChng = 1'b0;
        bus.PhaseRst = 1'b0;
        #1;
        RESET = 1'b1;
        wait_cycles(3);
        RESET  = 1'b0;
        mon_en = 1'b1;
        wait_cycles(3);

        strobe(11'd100);
        wait_cycles(20);
        phase_rst_pulse();
        wait_cycles(5);

        strobe(11'd1800);
        wait_cycles(25);

        strobe(11'd5);
        wait_cycles(3);
        strobe(11'd7);
        wait_cycles(30);

        strobe(11'd10);
        wait_cycles(2);
        strobe(11'd20);
        wait_cycles(1);
        strobe(11'd30);
        wait_cycles(30);

        strobe(11'd40);
        wait_cycles(11);
        strobe(11'd50);
        wait_cycles(30);

        strobe(11'd2047);
        wait_cycles(20);

        strobe(11'd300);
        wait_cycles(5);
        reset_mid_cycle();
        wait_cycles(10);

        strobe(11'd100);
        wait_cycles(20);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dds_phase_gen.md
DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 SHALL have parameter PHASE_W, default 24, meaning phase accumulator and tuning-word width.
REQ-002 SHALL have parameter ROM_AW, default 10, meaning waveform ROM address width, taken from the accumulator MSBs.
REQ-003 SHALL have parameter K_STEP, 13 bits, default 13'd1000, meaning tuning-word increment per frequency-code LSB; K_STEP*1800 SHALL be less than 2^PHASE_W.
REQ-004 SHALL have port Fg_CLK, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port Address, input, 11 bits: frequency code 0..1800 from the rotary stage.
REQ-007 SHALL have port FreqChng, input, 1 bit: one-cycle strobe meaning a new Address is valid.
REQ-008 SHALL have port PhaseRst, input, 1 bit: synchronous accumulator clear.
REQ-009 SHALL have port PhaseAddr, output, ROM_AW bits: waveform ROM address.
REQ-010 SHALL have port TuneWord, output, PHASE_W bits: active phase increment.
REQ-011 SHALL have port Busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port Update, output, 1 bit: one-cycle pulse on each TuneWord load.

Function
REQ-013 FSM states SHALL be IDLE, MUL and LOAD.
REQ-014 IDLE: FreqChng=1 captures Address into the multiplier shift register, clears the product and the bit counter, and moves to MUL.
REQ-015 MUL: on each of 11 edges, when the shift-register LSB is 1, K_STEP shifted left by the bit index SHALL be added to the product; the state moves to LOAD after the 11th edge.
REQ-016 LOAD: TuneWord <= product and Update=1 for exactly one cycle; the next state is IDLE, or MUL when pending is set.
REQ-017 Latency: FreqChng sampled at edge t0 SHALL make TuneWord change at edge t0+12.
REQ-018 FreqChng in MUL or LOAD SHALL set pending and store Address in a pending register; the last strobe wins. The in-flight multiply SHALL NOT be aborted.
REQ-019 On the LOAD-to-MUL transition the pending Address SHALL be loaded and pending cleared. FreqChng in that same LOAD cycle overrides the pending register.
REQ-020 Accumulator: acc <= acc + TuneWord on every cycle, modulo 2^PHASE_W (natural wrap). The old TuneWord SHALL be used until the load edge, so phase is continuous.
REQ-021 PhaseRst=1 SHALL set acc to 0 at that edge, with priority over the increment. TuneWord, the FSM and pending are unaffected.
REQ-022 PhaseAddr SHALL equal acc[PHASE_W-1 -: ROM_AW] (registered accumulator, no additional delay).
REQ-023 Address values above 1800 SHALL be clamped to 1800 at capture.

Reset
REQ-024 RESET=1 SHALL asynchronously force acc=0, TuneWord=0, state=IDLE, pending=0, Busy=0, Update=0 and PhaseAddr=0, including in the middle of a multiply.
REQ-025 After RESET is released, the first FreqChng SHALL behave exactly as REQ-014.

Configuration
REQ-026 Macro DDS_PHASE_DITHER_EN defined: a 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1; advances every cycle; reset to seed) SHALL have its low (PHASE_W-ROM_AW) bits added to acc before truncation to PhaseAddr. The accumulator itself SHALL NOT be modified.
REQ-027 Macro undefined: no LFSR logic; PhaseAddr is plain truncation per REQ-022.

Structure
REQ-028 Package dds_pkg SHALL hold the FSM state typedef, FREQ_W=11, FREQ_MAX=1800, MUL_CYCLES=11 and the LFSR seed/taps.
REQ-029 The shift-add multiplier SHALL be sub-module dds_shift_mul (start, operand, done, product); the FSM and accumulator remain in dds_phase_gen.

Verification
REQ-030 Reset scenario: assert RESET mid-run -> all outputs 0 immediately; after release PhaseAddr stays 0 with no FreqChng.
REQ-031 Single-update scenario: Address=100 with a FreqChng pulse at t0 -> Busy high for 12 cycles, TuneWord=100000 at t0+12, Update a single one-cycle pulse.
REQ-032 Wrap scenario: Address=1800 -> TuneWord=1800000; acc wraps modulo 2^24 after 10 increments (18000000-16777216=1222784).
REQ-033 Back-to-back scenario: Address=5 at t0, Address=7 at t0+4 -> TuneWord=5000 at t0+12, 7000 at t0+24, two Update pulses.
REQ-034 PhaseRst scenario: PhaseRst pulse while TuneWord=100000 -> acc=0 after that edge, then 100000 one cycle later; TuneWord unchanged.
REQ-035 Clamp/dither scenario: Address=2047 -> TuneWord=1800000. With DDS_PHASE_DITHER_EN, the PhaseAddr sequence matches a reference model seeded 16'hACE1.
